// File: rtl/i8088_bus_bridge.sv
// Bridges the 8088 minimum-mode multiplexed bus to single-beat memory/IO requests.
// Flow: IDLE -> ADDR (address latched) -> REQ (handshake) -> WAIT (read only) -> HOLD (strobe release).
module i8088_bus_bridge #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  ERR_RDATA      = 8'hFF
) (
  input  logic        CORE_CLK,
  input  logic        RESETN,
  input  logic [7:0]  cpu_ad_in,
  input  logic [11:0] cpu_a_hi,
  input  logic        cpu_ale,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_io_m,
  output logic [7:0]  cpu_ad_out,
  output logic        cpu_ad_oe,
  output logic        cpu_ready,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_write,
  output logic        req_io,
  output logic [19:0] req_addr,
  output logic [7:0]  req_wdata,
  input  logic        resp_valid,
  input  logic [7:0]  resp_rdata,
  output logic        err_timeout,
  output logic        err_proto
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  // Idle pin levels: ALE low, both strobes high.
  localparam logic [23:0] SYNC_RST = 24'h60_0000;

  logic [23:0]                  pin_bus;
  logic [SYNC_STAGES-1:0][23:0] sync_q;
  logic [23:0]                  sync_s;
  logic [2:0]                   prev_q;

  logic        ale_s, rd_s, wr_s, io_m_s;
  logic [11:0] a_hi_s;
  logic [7:0]  ad_s;
  logic        ale_rise, ale_fall, rd_fall, wr_fall;

  logic [2:0]  state_q, state_d;
  logic [19:0] addr_q, addr_d;
  logic        io_q, io_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  ad_out_q, ad_out_d;
  logic        oe_q, oe_d;
  logic        ready_q, ready_d;
  logic        req_valid_q, req_valid_d;
  logic        req_write_q, req_write_d;
  logic        req_io_q, req_io_d;
  logic [19:0] req_addr_q, req_addr_d;
  logic [7:0]  req_wdata_q, req_wdata_d;
  logic        err_to_q, err_to_d;
  logic        err_proto_q, err_proto_d;

  assign pin_bus = {cpu_ale, cpu_rd_n, cpu_wr_n, cpu_io_m, cpu_a_hi, cpu_ad_in};
  assign sync_s  = sync_q[SYNC_STAGES-1];
  assign ale_s   = sync_s[23];
  assign rd_s    = sync_s[22];
  assign wr_s    = sync_s[21];
  assign io_m_s  = sync_s[20];
  assign a_hi_s  = sync_s[19:8];
  assign ad_s    = sync_s[7:0];

  assign ale_rise = ale_s & ~prev_q[2];
  assign ale_fall = ~ale_s & prev_q[2];
  assign rd_fall  = ~rd_s & prev_q[1];
  assign wr_fall  = ~wr_s & prev_q[0];

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    io_d        = io_q;
    cnt_d       = cnt_q;
    ad_out_d    = ad_out_q;
    oe_d        = oe_q;
    ready_d     = ready_q;
    req_valid_d = req_valid_q;
    req_write_d = req_write_q;
    req_io_d    = req_io_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    err_to_d    = 1'b0;
    err_proto_d = 1'b0;

    if (ale_rise && state_q != S_IDLE) err_proto_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (ale_rise) ready_d = 1'b0;
        if (ale_fall) begin
          addr_d  = {a_hi_s, ad_s};
          io_d    = io_m_s;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (!rd_s && !wr_s) begin
          err_proto_d = 1'b1;
          ready_d     = 1'b1;
          state_d     = S_IDLE;
        end else if (rd_fall || wr_fall) begin
          req_valid_d = 1'b1;
          req_write_d = wr_fall;
          req_addr_d  = addr_q;
          req_io_d    = io_q;
          if (wr_fall) req_wdata_d = ad_s;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (req_ready) begin
          req_valid_d = 1'b0;
          if (req_write_q) begin
            ready_d = 1'b1;
            state_d = S_HOLD;
          end else begin
            cnt_d   = 16'd0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (resp_valid) begin
          ad_out_d = resp_rdata;
          oe_d     = 1'b1;
          ready_d  = 1'b1;
          state_d  = S_HOLD;
        end else if (cnt_q == TO_LAST) begin
          ad_out_d = ERR_RDATA;
          oe_d     = 1'b1;
          ready_d  = 1'b1;
          err_to_d = 1'b1;
          state_d  = S_HOLD;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_HOLD: begin
        // Level test so the pad is released even if the strobe rose before HOLD.
        if (req_write_q ? wr_s : rd_s) begin
          oe_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CORE_CLK) begin
    if (!RESETN) begin
      sync_q      <= {SYNC_STAGES{SYNC_RST}};
      prev_q      <= 3'b011;
      state_q     <= S_IDLE;
      addr_q      <= '0;
      io_q        <= 1'b0;
      cnt_q       <= '0;
      ad_out_q    <= '0;
      oe_q        <= 1'b0;
      ready_q     <= 1'b1;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      req_io_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      err_to_q    <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], pin_bus};
      prev_q      <= {ale_s, rd_s, wr_s};
      state_q     <= state_d;
      addr_q      <= addr_d;
      io_q        <= io_d;
      cnt_q       <= cnt_d;
      ad_out_q    <= ad_out_d;
      oe_q        <= oe_d;
      ready_q     <= ready_d;
      req_valid_q <= req_valid_d;
      req_write_q <= req_write_d;
      req_io_q    <= req_io_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      err_to_q    <= err_to_d;
      err_proto_q <= err_proto_d;
    end
  end

  assign cpu_ad_out  = ad_out_q;
  assign cpu_ad_oe   = oe_q;
  assign cpu_ready   = ready_q;
  assign req_valid   = req_valid_q;
  assign req_write   = req_write_q;
  assign req_io      = req_io_q;
  assign req_addr    = req_addr_q;
  assign req_wdata   = req_wdata_q;
  assign err_timeout = err_to_q;
  assign err_proto   = err_proto_q;

endmodule

// File: doc/i8088_bus_bridge.md
Name: i8088_bus_bridge

Overview:
- Converts the external 8088 minimum-mode multiplexed bus into single-beat memory/IO requests for the AXI device subsystem, and returns read data onto the AD bus.
- Sits between the ck_io* CPU pins (AD7..0, A19..8, ALE, nRD, nWR, IO/nM) and the request port of the axi_devs wrapper.
- Generates the CPU READY signal, holding wait states until the subsystem completes each transfer.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on every asynchronous CPU input; legal range 2..4.
- TIMEOUT_CYCLES, 1024, CORE_CLK cycles allowed in S_WAIT before the bridge aborts the transfer; legal range 16..65535.
- ERR_RDATA, 8'hFF, byte returned to the CPU on a read timeout.

Ports:
- CORE_CLK  in  1  core clock; all logic is on its rising edge.
- RESETN  in  1  synchronous, active-low reset.
- cpu_ad_in  in  8  AD7..0 input from the pins.
- cpu_a_hi  in  12  A19..A8 from the pins.
- cpu_ale  in  1  address latch enable.
- cpu_rd_n  in  1  read strobe, active low.
- cpu_wr_n  in  1  write strobe, active low.
- cpu_io_m  in  1  1 = IO cycle, 0 = memory cycle.
- cpu_ad_out  out  8  read data driven onto AD7..0.
- cpu_ad_oe  out  1  AD pad output enable.
- cpu_ready  out  1  READY to the CPU.
- req_valid  out  1  request valid.
- req_ready  in  1  request accepted.
- req_write  out  1  1 = write, 0 = read.
- req_io  out  1  IO space flag.
- req_addr  out  20  byte address.
- req_wdata  out  8  write data.
- resp_valid  in  1  read data valid (single-cycle pulse).
- resp_rdata  in  8  read data.
- err_timeout  out  1  one-cycle pulse when a transfer times out.
- err_proto  out  1  one-cycle pulse on a bus protocol violation.

Behaviour:
- Reset values: cpu_ad_out=0, cpu_ad_oe=0, cpu_ready=1, req_valid=0, req_write=0, req_io=0, req_addr=0, req_wdata=0, err_*=0, state=S_IDLE.
- All cpu_* inputs pass through SYNC_STAGES flip-flops. Edge detection uses the synchronised value and its previous-cycle copy.
- Writes are posted. Reads are not.

State machine:
- S_IDLE
  - On synced ALE rise: cpu_ready<=0.
  - On synced ALE fall: latch addr={cpu_a_hi, synced AD} and io_m; go to S_ADDR.
- S_ADDR
  - Synced rd_n fall: load the request (req_write=0) and go to S_REQ.
  - Synced wr_n fall: capture synced AD into req_wdata, load the request (req_write=1) and go to S_REQ.
  - rd_n and wr_n both low in the same cycle: pulse err_proto, set cpu_ready=1, return to S_IDLE.
- S_REQ
  - Hold req_valid=1 with all req_* fields stable until req_ready=1 (handshake when both are high).
  - Write: on handshake, req_valid<=0, cpu_ready<=1, go to S_HOLD.
  - Read: on handshake, go to S_WAIT.
- S_WAIT
  - A 16-bit counter starts at 0 on entry.
  - On resp_valid: cpu_ad_out<=resp_rdata, cpu_ad_oe<=1, cpu_ready<=1, go to S_HOLD.
  - When the counter reaches TIMEOUT_CYCLES with no response: cpu_ad_out<=ERR_RDATA, cpu_ad_oe=1, cpu_ready=1, pulse err_timeout, go to S_HOLD.
  - After a timeout, a late resp_valid is ignored.
- S_HOLD
  - Keep the output data held until the active strobe rises (synced), then cpu_ad_oe<=0 and go to S_IDLE.

Boundary and protocol rules:
- The timeout counter does not run in S_REQ. Backpressure from req_ready is unbounded.
- A synced ALE rise in any state other than S_IDLE: pulse err_proto and otherwise ignore it (no re-latch).
- resp_valid outside S_WAIT is ignored.
- cpu_ad_oe is never 1 while synced rd_n is high for two or more consecutive cycles.
- A reset asserted mid-transfer returns all outputs to their reset values on the next edge. A response arriving after reset is ignored.
- Latency from synced rd_n fall to req_valid: 1 cycle. From resp_valid to cpu_ready=1: 1 cycle.

Test Plan:
- Memory read at 0xF_FFF0 with an immediate responder returning 0xEA: req_addr=0xFFFF0, req_io=0, req_write=0; cpu_ready low until 1 cycle after resp_valid; cpu_ad_out=0xEA with oe=1 until rd_n rises.
- IO write of 0x5A to port 0x0080 with req_ready held low for 50 cycles: req_valid stays high and stable for 50 cycles; req_io=1, req_wdata=0x5A; cpu_ready=1 one cycle after the handshake.
- Read with no response, TIMEOUT_CYCLES=16: err_timeout pulses once after 16 cycles in S_WAIT; cpu_ad_out=0xFF; a resp_valid injected afterwards does not change cpu_ad_out.
- rd_n and wr_n driven low together after ALE: err_proto pulses; no req_valid; cpu_ready returns to 1.
- RESETN pulsed low for 1 cycle during S_WAIT: outputs return to reset values (cpu_ready=1, oe=0); the next full read cycle completes normally.
- Second ALE pulse during S_REQ: err_proto pulses; req_addr is unchanged and the original transfer completes.
